// File: rtl/branch_resolve_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve_queue_if
// Brief    : ID/execute/fetch-side signal bundle for the branch resolve queue.
// Revision : 1.0 - initial release
// ============================================================================
interface branch_resolve_queue_if #(
    parameter int TAG_W  = 2,
    parameter int ADDR_W = 32
);
    // ID-stage enqueue
    logic              id_valid;
    logic              id_ready;
    logic [ADDR_W-1:0] id_pc;
    logic              id_is_determined;
    logic              id_is_taken;
    logic [ADDR_W-1:0] id_target;
    logic              id_pred_taken;
    logic [ADDR_W-1:0] id_pred_target;
    logic [TAG_W-1:0]  id_tag;

    // Execute-stage resolution broadcast
    logic              ex_valid;
    logic [TAG_W-1:0]  ex_tag;
    logic              ex_taken;
    logic [ADDR_W-1:0] ex_target;

    // Retire / redirect towards fetch
    logic              retire_valid;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic [TAG_W:0]    count;

    modport master (
        output id_valid, id_pc, id_is_determined, id_is_taken, id_target,
               id_pred_taken, id_pred_target,
               ex_valid, ex_tag, ex_taken, ex_target,
        input  id_ready, id_tag, retire_valid, redirect_valid, redirect_pc, count
    );

    modport slave (
        input  id_valid, id_pc, id_is_determined, id_is_taken, id_target,
               id_pred_taken, id_pred_target,
               ex_valid, ex_tag, ex_taken, ex_target,
        output id_ready, id_tag, retire_valid, redirect_valid, redirect_pc, count
    );
endinterface
`default_nettype wire

// File: rtl/branch_resolve_queue.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve_queue
// Brief    : In-order branch queue; retires resolved branches and issues a
//            one-cycle redirect plus full flush on a mispredict.
// Revision : 1.0 - initial release
// ============================================================================
module branch_resolve_queue #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 2,
    parameter int ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    branch_resolve_queue_if.slave bus
);

    localparam logic [TAG_W:0]    c_full_count = (TAG_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] c_slot_skip  = ADDR_W'(8);

    // Per-entry state; valid/resolved are reset, payload is not.
    logic [DEPTH-1:0]  r_valid;
    logic [DEPTH-1:0]  r_resolved;
    logic [ADDR_W-1:0] r_pc          [DEPTH];
    logic              r_pred_taken  [DEPTH];
    logic [ADDR_W-1:0] r_pred_target [DEPTH];
    logic              r_taken       [DEPTH];
    logic [ADDR_W-1:0] r_target      [DEPTH];

    logic [TAG_W-1:0]  r_rptr;
    logic [TAG_W-1:0]  r_wptr;
    logic [TAG_W:0]    r_count;
    logic              r_retire_valid;
    logic              r_redirect_valid;
    logic [ADDR_W-1:0] r_redirect_pc;

    logic              w_id_ready;
    logic              w_enq;
    logic              w_resolve;
    logic              w_retire;
    logic              w_mispredict;
    logic              w_flush;
    logic [ADDR_W-1:0] w_redirect_target;

    assign w_id_ready = (r_count < c_full_count) && !r_redirect_valid;
    assign w_enq      = bus.id_valid && w_id_ready;

    // The slot being allocated this cycle is never a resolve target.
    assign w_resolve  = bus.ex_valid
                     && r_valid[bus.ex_tag]
                     && !r_resolved[bus.ex_tag]
                     && !(w_enq && (bus.ex_tag == r_wptr));

    // Uses the registered resolved bit, so retire trails resolve by a cycle.
    assign w_retire   = r_valid[r_rptr] && r_resolved[r_rptr];

    assign w_mispredict = (r_taken[r_rptr] != r_pred_taken[r_rptr])
                       || (r_taken[r_rptr] && (r_target[r_rptr] != r_pred_target[r_rptr]));

    assign w_flush    = w_retire && w_mispredict;

    // Not-taken fall-through skips the delay slot.
    assign w_redirect_target = r_taken[r_rptr] ? r_target[r_rptr]
                                               : (r_pc[r_rptr] + c_slot_skip);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid          <= '0;
            r_resolved       <= '0;
            r_rptr           <= '0;
            r_wptr           <= '0;
            r_count          <= '0;
            r_retire_valid   <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
        end else begin
            r_retire_valid   <= w_retire;
            r_redirect_valid <= w_flush;
            if (w_flush) begin
                r_redirect_pc <= w_redirect_target;
                r_valid       <= '0;
                r_resolved    <= '0;
                r_rptr        <= '0;
                r_wptr        <= '0;
                r_count       <= '0;
            end else begin
                if (w_retire) begin
                    r_valid[r_rptr]    <= 1'b0;
                    r_resolved[r_rptr] <= 1'b0;
                    r_rptr             <= r_rptr + 1'b1;
                end
                if (w_resolve) begin
                    r_resolved[bus.ex_tag] <= 1'b1;
                end
                if (w_enq) begin
                    r_valid[r_wptr]    <= 1'b1;
                    r_resolved[r_wptr] <= bus.id_is_determined;
                    r_wptr             <= r_wptr + 1'b1;
                end
                case ({w_enq, w_retire})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Payload writes; enqueue and resolve never target the same slot.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_pc[r_wptr]          <= bus.id_pc;
            r_pred_taken[r_wptr]  <= bus.id_pred_taken;
            r_pred_target[r_wptr] <= bus.id_pred_target;
            r_taken[r_wptr]       <= bus.id_is_taken;
            r_target[r_wptr]      <= bus.id_target;
        end
        if (w_resolve) begin
            r_taken[bus.ex_tag]  <= bus.ex_taken;
            r_target[bus.ex_tag] <= bus.ex_target;
        end
    end

    assign bus.id_ready       = w_id_ready;
    assign bus.id_tag         = r_wptr;
    assign bus.retire_valid   = r_retire_valid;
    assign bus.redirect_valid = r_redirect_valid;
    assign bus.redirect_pc    = r_redirect_pc;
    assign bus.count          = r_count;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_resolve_queue
// Brief    : Directed self-checking bench for branch_resolve_queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_queue;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    logic [1:0] head_tag;

    branch_resolve_queue_if #(.TAG_W(2), .ADDR_W(32)) bus ();

    branch_resolve_queue #(.DEPTH(4), .TAG_W(2), .ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_id(input logic v, input logic [31:0] pc, input logic det,
                            input logic tk, input logic [31:0] tgt,
                            input logic ptk, input logic [31:0] ptgt);
        bus.id_valid         = v;
        bus.id_pc            = pc;
        bus.id_is_determined = det;
        bus.id_is_taken      = tk;
        bus.id_target        = tgt;
        bus.id_pred_taken    = ptk;
        bus.id_pred_target   = ptgt;
    endtask

    task automatic drive_ex(input logic v, input logic [1:0] tag,
                            input logic tk, input logic [31:0] tgt);
        bus.ex_valid  = v;
        bus.ex_tag    = tag;
        bus.ex_taken  = tk;
        bus.ex_target = tgt;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        drive_id(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        drive_ex(1'b0, 2'd0, 1'b0, 32'h0);

        // Reset state
        tick();
        tick();
        chk("rst_count",    bus.count, 0);
        chk("rst_retire",   bus.retire_valid, 0);
        chk("rst_redirect", bus.redirect_valid, 0);
        chk("rst_rpc",      bus.redirect_pc, 0);
        chk("rst_ready",    bus.id_ready, 1);
        chk("rst_tag",      bus.id_tag, 0);
        rst = 1'b1;

        // Correctly predicted determined branch
        drive_id(1'b1, 32'h100, 1'b1, 1'b1, 32'h200, 1'b1, 32'h200);
        tick();
        drive_id(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("t1_count1",  bus.count, 1);
        chk("t1_noret",   bus.retire_valid, 0);
        chk("t1_tag",     bus.id_tag, 1);
        tick();
        chk("t1_retire",  bus.retire_valid, 1);
        chk("t1_noredir", bus.redirect_valid, 0);
        chk("t1_count0",  bus.count, 0);
        tick();
        chk("t1_retoff",  bus.retire_valid, 0);

        // Determined mispredict (not taken, predicted taken)
        drive_id(1'b1, 32'h100, 1'b1, 1'b0, 32'h0, 1'b1, 32'h200);
        tick();
        drive_id(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("t2_count1", bus.count, 1);
        chk("t2_noredir", bus.redirect_valid, 0);
        tick();
        chk("t2_redir",  bus.redirect_valid, 1);
        chk("t2_rpc",    bus.redirect_pc, 32'h108);
        chk("t2_count0", bus.count, 0);
        chk("t2_ready0", bus.id_ready, 0);
        chk("t2_tag0",   bus.id_tag, 0);
        tick();
        chk("t2_redoff", bus.redirect_valid, 0);
        chk("t2_ready1", bus.id_ready, 1);

        // Fill with 4 undetermined branches, predicted not taken
        for (int i = 0; i < 4; i++) begin
            chk("t3_tag", bus.id_tag, i);
            drive_id(1'b1, 32'h10 * (i + 1), 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
            tick();
        end
        chk("t3_full",   bus.count, 4);
        chk("t3_ready0", bus.id_ready, 0);
        tick();
        drive_id(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("t3_fullhold", bus.count, 4);
        chk("t3_tagwrap",  bus.id_tag, 0);
        drive_ex(1'b1, 2'd2, 1'b0, 32'h0);
        tick();
        chk("t3_noret_a", bus.retire_valid, 0);
        drive_ex(1'b1, 2'd0, 1'b0, 32'h0);
        tick();
        drive_ex(1'b0, 2'd0, 1'b0, 32'h0);
        chk("t3_noret_b", bus.retire_valid, 0);
        tick();
        chk("t3_ret0",    bus.retire_valid, 1);
        chk("t3_count3",  bus.count, 3);
        // Late resolve of already-resolved tag 2 must be ignored
        drive_ex(1'b1, 2'd2, 1'b1, 32'h999);
        tick();
        chk("t3_block1",  bus.retire_valid, 0);
        chk("t3_count3b", bus.count, 3);
        drive_ex(1'b1, 2'd1, 1'b0, 32'h0);
        tick();
        drive_ex(1'b0, 2'd0, 1'b0, 32'h0);
        chk("t3_noret_c", bus.retire_valid, 0);
        tick();
        chk("t3_ret1",    bus.retire_valid, 1);
        chk("t3_count2",  bus.count, 2);
        tick();
        chk("t3_ret2",    bus.retire_valid, 1);
        chk("t3_ret2_nr", bus.redirect_valid, 0);
        chk("t3_count1",  bus.count, 1);
        tick();
        chk("t3_blk3",    bus.retire_valid, 0);
        drive_ex(1'b1, 2'd3, 1'b0, 32'h0);
        tick();
        drive_ex(1'b0, 2'd0, 1'b0, 32'h0);
        tick();
        chk("t3_ret3",    bus.retire_valid, 1);
        chk("t3_count0",  bus.count, 0);
        tick();

        // Mispredict at head of a full queue flushes younger entries
        drive_id(1'b1, 32'h500, 1'b0, 1'b0, 32'h0, 1'b1, 32'h300);
        tick();
        for (int i = 1; i < 4; i++) begin
            drive_id(1'b1, 32'h500 + 32'h4 * i, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
            tick();
        end
        drive_id(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("t4_full", bus.count, 4);
        drive_ex(1'b1, 2'd0, 1'b1, 32'h400);
        tick();
        drive_ex(1'b0, 2'd0, 1'b0, 32'h0);
        tick();
        chk("t4_redir",  bus.redirect_valid, 1);
        chk("t4_rpc",    bus.redirect_pc, 32'h400);
        chk("t4_count0", bus.count, 0);
        chk("t4_tag0",   bus.id_tag, 0);
        drive_ex(1'b1, 2'd1, 1'b0, 32'h0);
        drive_id(1'b1, 32'h700, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        drive_ex(1'b0, 2'd0, 1'b0, 32'h0);
        drive_id(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("t4_redoff", bus.redirect_valid, 0);
        chk("t4_count0b", bus.count, 0);
        chk("t4_tag0b",  bus.id_tag, 0);
        tick();
        chk("t4_noghost", bus.retire_valid, 0);
        chk("t4_count0c", bus.count, 0);

        // Wrap-around with back-to-back enqueue/retire
        for (int i = 0; i < 6; i++) begin
            chk("t5_tag", bus.id_tag, i % 4);
            drive_id(1'b1, 32'h800 + 32'h4 * i, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
            tick();
            chk("t5_count", bus.count, 1);
            chk("t5_ret", bus.retire_valid, (i == 0) ? 1'b0 : 1'b1);
            chk("t5_noredir", bus.redirect_valid, 0);
        end
        drive_id(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        chk("t5_lastret", bus.retire_valid, 1);
        chk("t5_count0",  bus.count, 0);
        chk("t5_tag2",    bus.id_tag, 2);

        // Reset with pending entries and a resolved mispredict at the head
        head_tag = bus.id_tag;
        drive_id(1'b1, 32'h900, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        tick();
        tick();
        drive_id(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("t6_count3", bus.count, 3);
        drive_ex(1'b1, head_tag, 1'b1, 32'hA00);
        tick();
        drive_ex(1'b0, 2'd0, 1'b0, 32'h0);
        rst = 1'b0;
        tick();
        chk("t6_noredir", bus.redirect_valid, 0);
        chk("t6_count0",  bus.count, 0);
        chk("t6_ready",   bus.id_ready, 1);
        chk("t6_rpc0",    bus.redirect_pc, 0);
        rst = 1'b1;
        tick();
        chk("t6_noredir2", bus.redirect_valid, 0);
        chk("t6_noret",    bus.retire_valid, 0);
        chk("t6_tag0",     bus.id_tag, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
